// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing with majority-vote sampling.
// Optional parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_frame_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       S_DATA,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] edge_count,
    input  logic [3:0] bit_count,
    output logic       edge_bit_en,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_e;
`endif

    state_e     state_q, state_d;
    logic [5:0] psc_q, psc_d;
    logic [7:0] shift_q, shift_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       bit_q, bit_d;
    logic [7:0] p_data_q, p_data_d;
    logic       dv_q, dv_d;
    logic       pe_q, pe_d;
    logic       se_q, se_d;

`ifdef UART_RX_PARITY_EN
    logic       par_en_q, par_en_d;
    logic       par_typ_q, par_typ_d;
    logic       mis_q, mis_d;
`else
    logic       unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    logic [5:0] half;
    logic       at_s0, at_s1, at_vote, bit_end;

    assign half    = {1'b0, psc_q[5:1]};
    assign at_s0   = (edge_count == half - 6'd1);
    assign at_s1   = (edge_count == half);
    assign at_vote = (edge_count == half + 6'd1);
    assign bit_end = (edge_count == psc_q - 6'd1);

    assign edge_bit_en = (state_q != IDLE);
    assign P_DATA      = p_data_q;
    assign data_valid  = dv_q;
    assign par_err     = pe_q;
    assign stp_err     = se_q;

    always_comb begin
        state_d  = state_q;
        psc_d    = psc_q;
        shift_d  = shift_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        bit_d    = bit_q;
        p_data_d = p_data_q;
        dv_d     = 1'b0;
        pe_d     = 1'b0;
        se_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        mis_d     = mis_q;
`endif

        // three-point majority vote around the bit centre
        if (edge_bit_en) begin
            if (at_s0) s0_d = S_DATA;
            if (at_s1) s1_d = S_DATA;
            if (at_vote) begin
                bit_d = (s0_q & s1_q) | (s0_q & S_DATA) | (s1_q & S_DATA);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!S_DATA) begin
                    state_d = START;
                    psc_d   = Prescale;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    mis_d     = 1'b0;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = bit_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {bit_q, shift_q[7:1]};
                    if (bit_count == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    mis_d   = bit_q != (^shift_q ^ par_typ_q);
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    se_d    = ~bit_q;
`ifdef UART_RX_PARITY_EN
                    pe_d = mis_q;
                    if (bit_q && !mis_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
`else
                    if (bit_q) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            psc_q    <= 6'd8;
            shift_q  <= 8'h00;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
            bit_q    <= 1'b1;
            p_data_q <= 8'h00;
            dv_q     <= 1'b0;
            pe_q     <= 1'b0;
            se_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            shift_q  <= shift_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            bit_q    <= bit_d;
            p_data_q <= p_data_d;
            dv_q     <= dv_d;
            pe_q     <= pe_d;
            se_q     <= se_d;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            mis_q     <= mis_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized bench for uart_rx_frame_ctrl with a frame-level reference model
// and a behavioural edge/bit counter.
module tb_uart_rx_frame_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       S_DATA = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] ec = '0;
    logic [3:0] bc = '0;
    logic       edge_bit_en;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_chk = 0;
    int n_pass = 0;
    int n_dv = 0;
    int n_pe = 0;
    int n_se = 0;
    logic [7:0] exp_pdata = 8'h00;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    uart_rx_frame_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .S_DATA     (S_DATA),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .edge_count (ec),
        .bit_count  (bc),
        .edge_bit_en(edge_bit_en),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!edge_bit_en) begin
            ec <= '0;
            bc <= '0;
        end else if (ec == Prescale - 6'd1) begin
            ec <= '0;
            bc <= bc + 4'd1;
        end else begin
            ec <= ec + 6'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (data_valid) n_dv++;
        if (par_err) n_pe++;
        if (stp_err) n_se++;
    endtask

    // Drive one frame, then compare the frame's pulses and P_DATA to the model.
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input int psc, input bit pen, input bit ptyp,
                              input bit flip, input bit stop, input int gbit,
                              input int gap);
        logic bits [0:10];
        int   n;
        bit   has_par;
        bit   e_pe, e_se, e_dv;
        int   dv0, pe0, se0;
        has_par = PAR_BUILD && pen;
        n = has_par ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        if (has_par) bits[9] = ^d ^ ptyp ^ flip;
        bits[n-1] = stop;
        e_se = !stop;
        e_pe = has_par && flip;
        e_dv = !e_se && !e_pe;
        if (e_dv) exp_pdata = d;
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        Prescale = psc[5:0];
        PAR_EN = pen;
        PAR_TYP = ptyp;
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < psc; c++) begin
                S_DATA = bits[j];
                if (gbit >= 0 && j == gbit + 1 && c == psc / 2 + 1)
                    S_DATA = ~bits[j];
                tick();
                if (j == 0 && c == 0) begin
                    PAR_EN = 1'($urandom);
                    PAR_TYP = 1'($urandom);
                end
                if (j == 1 && c == 0) chk({tag, " en_busy"}, edge_bit_en, 1);
            end
        end
        S_DATA = 1'b1;
        tick();
        chk({tag, " dv"}, n_dv - dv0, e_dv);
        chk({tag, " par_err"}, n_pe - pe0, e_pe);
        chk({tag, " stp_err"}, n_se - se0, e_se);
        chk({tag, " p_data"}, P_DATA, exp_pdata);
        chk({tag, " en_idle"}, edge_bit_en, 0);
        for (int g = 0; g < gap; g++) tick();
    endtask

    initial begin
        int dv0, pe0, se0;
        logic [7:0] rd;
        int psc;
        repeat (3) tick();
        RST = 1'b0;
        chk("rst p_data", P_DATA, 8'h00);
        chk("rst dv", data_valid, 0);
        chk("rst par_err", par_err, 0);
        chk("rst stp_err", stp_err, 0);
        chk("rst en", edge_bit_en, 0);
        n_dv = 0; n_pe = 0; n_se = 0;
        tick();

        send_frame("a5_p8", 8'hA5, 8, 0, 0, 0, 1, -1, 2);
        send_frame("3c_par", 8'h3C, 16, 1, 0, 1, 1, -1, 1);
        send_frame("5a_stop", 8'h5A, 32, 0, 0, 0, 0, -1, 0);

        // short start pulse must abort without any output
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        Prescale = 6'd8;
        S_DATA = 1'b0;
        repeat (2) tick();
        S_DATA = 1'b1;
        repeat (16) tick();
        chk("glitch_start pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
        chk("glitch_start en", edge_bit_en, 0);
        chk("glitch_start p_data", P_DATA, exp_pdata);

        send_frame("ff_vote", 8'hFF, 8, 0, 0, 0, 1, 3, 0);

        // reset in the middle of data bit 5
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        Prescale = 6'd16;
        rd = 8'h5A;
        for (int j = 0; j < 7; j++) begin
            for (int c = 0; c < ((j == 6) ? 8 : 16); c++) begin
                S_DATA = (j == 0) ? 1'b0 : rd[j-1];
                tick();
            end
        end
        RST = 1'b1;
        S_DATA = 1'b1;
        tick();
        RST = 1'b0;
        exp_pdata = 8'h00;
        chk("midrst p_data", P_DATA, 8'h00);
        chk("midrst en", edge_bit_en, 0);
        repeat (40) tick();
        chk("midrst pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
        send_frame("81_after_rst", 8'h81, 16, 0, 0, 0, 1, -1, 1);

        for (int k = 0; k < 40; k++) begin
            psc = 8 << $urandom_range(0, 2);
            send_frame("rand", 8'($urandom), psc, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                       $urandom_range(0, 3));
        end

        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        repeat (100) tick();
        chk("tail pulses", (n_dv - dv0) + (n_pe - pe0) + (n_se - se0), 0);
        chk("tail p_data", P_DATA, exp_pdata);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-003 SHALL have port S_DATA  input  1  serial RX line, idle high.
REQ-004 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-005 SHALL have port PAR_EN  input  1  parity bit present in frame.
REQ-006 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 SHALL have port edge_count  input  6  edge index within the current bit, 0..Prescale-1, from the edge/bit counter.
REQ-008 SHALL have port bit_count  input  4  bit index within the frame (start = 0), from the edge/bit counter.
REQ-009 SHALL have port edge_bit_en  output  1  enable to the edge/bit counter; counters clear while low.
REQ-010 SHALL have port P_DATA  output  8  last good received byte.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-012 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-013 SHALL have port stp_err  output  1  one-cycle pulse on stop bit sampled low.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; edge_bit_en = 1 in every state except IDLE, decoded from the state register.
REQ-015 SHALL capture S_DATA at edge_count = Prescale/2-1 and Prescale/2, then register sampled_bit = majority of those two captures and S_DATA at edge_count = Prescale/2+1.
REQ-016 SHALL define bit-end as edge_count == Prescale-1; all state decisions occur only at bit-end.
REQ-017 IDLE: S_DATA = 0 -> START on the next cycle; otherwise remain in IDLE.
REQ-018 START at bit-end: sampled_bit = 1 (glitch) -> IDLE with no flags; sampled_bit = 0 -> DATA.
REQ-019 DATA at bit-end: shift sampled_bit in LSB-first (insert at bit 7, shift right); at bit_count = 8 -> PARITY if parity is enabled, else STOP.
REQ-020 PARITY at bit-end: record mismatch = sampled_bit != (XOR of 8 data bits XOR PAR_TYP); -> STOP.
REQ-021 STOP at bit-end: -> IDLE; on the next cycle pulse stp_err = ~sampled_bit and par_err = recorded mismatch.
REQ-022 On a clean frame, SHALL load P_DATA from the shift register and pulse data_valid on that same cycle, one cycle after STOP bit-end.
REQ-023 If either error pulses, data_valid SHALL stay 0 and P_DATA SHALL hold its previous value.
REQ-024 Back-to-back frames: S_DATA = 0 on the first IDLE cycle after STOP SHALL start a new frame with no lost start bit.
REQ-025 PAR_EN, PAR_TYP and Prescale SHALL be sampled only on the IDLE->START transition and held for the whole frame.
REQ-026 All outputs SHALL be registered, except edge_bit_en.

Reset
REQ-027 RST = 1 SHALL force IDLE, edge_bit_en = 0, P_DATA = 0x00, and data_valid = par_err = stp_err = 0 on the next edge, including mid-frame; a partial frame SHALL be discarded.

Configuration
REQ-028 UART_RX_PARITY_EN defined: PARITY state and par_err logic are present, governed by PAR_EN/PAR_TYP.
REQ-029 UART_RX_PARITY_EN undefined: no PARITY state; DATA -> STOP after bit_count = 8; PAR_EN and PAR_TYP are ignored; par_err is tied to 0.

Verification
REQ-030 Prescale = 8, PAR_EN = 0, byte 0xA5 -> P_DATA = 0xA5, data_valid pulses once, no error flags.
REQ-031 Prescale = 16, PAR_EN = 1, PAR_TYP = 0, byte 0x3C with parity bit 1 -> par_err = 1, data_valid = 0, P_DATA unchanged.
REQ-032 Prescale = 32, byte 0x5A with stop bit 0 -> stp_err = 1, data_valid = 0.
REQ-033 S_DATA low for only 2 cycles at Prescale = 8 -> return to IDLE at START bit-end, no output pulses.
REQ-034 Single-cycle glitch on the middle sample of data bit 3 of 0xFF -> P_DATA = 0xFF (majority vote).
REQ-035 RST pulse during DATA bit 5, then clean frame 0x81 -> only data_valid with P_DATA = 0x81.
